sisc_dm_responder: RTL

//  Data-memory responder for the SISC multi-cycle CPU. It is the slave end of the CPU's data-memory

---
 rtl/sisc_mem_pkg.sv | 24 ++
 rtl/sisc_dm_array.sv | 38 +++
 rtl/sisc_dm_responder.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/sisc_mem_pkg.sv
// ============================================================================
//  Module      : sisc_mem_pkg
//  Description : Shared constants and types for the SISC data-memory path:
//                default bus widths, wait-counter width, responder states.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package sisc_mem_pkg;

    localparam int c_DATA_W = 32;   // default data word width
    localparam int c_ADDR_W = 16;   // default word address width
    localparam int c_CNT_W  = 4;    // wait-state counter width (0..15)

    // Responder FSM encoding
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } dm_state_e;

endpackage : sisc_mem_pkg

`default_nettype wire

// File: rtl/sisc_dm_array.sv
// ============================================================================
//  Module      : sisc_dm_array
//  Description : Single-port synchronous RAM, DEPTH x DATA_W. A write or a
//                read happens only when i_en is high; read data registers on
//                the same edge and holds until the next enabled read.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module sisc_dm_array #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 1024,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              i_en,
    input  logic              i_we,
    input  logic [AW-1:0]     i_addr,
    input  logic [DATA_W-1:0] i_wdata,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH];

    // Storage has no reset so contents survive a reset of the responder
    always_ff @(posedge clk) begin
        if (i_en) begin
            if (i_we) begin
                r_mem[i_addr] <= i_wdata;
            end else begin
                o_rdata <= r_mem[i_addr];
            end
        end
    end

endmodule : sisc_dm_array

`default_nettype wire

// File: rtl/sisc_dm_responder.sv
// ============================================================================
//  Module      : sisc_dm_responder
//  Description : Data-memory responder for the SISC multi-cycle CPU. Captures
//                one load/store request, inserts WAIT_CYCLES wait states,
//                commits the access and issues a one-cycle ack (with err for
//                out-of-range addresses).
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module sisc_dm_responder
    import sisc_mem_pkg::*;
#(
    parameter int DATA_W      = c_DATA_W,
    parameter int ADDR_W      = c_ADDR_W,
    parameter int DEPTH       = 1024,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst_f,
    input  logic              mem_req,
    input  logic              mem_we,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic [DATA_W-1:0] mem_rdata,
    output logic              mem_ack,
    output logic              mem_err,
    output logic              mem_busy
);

    localparam int              c_AW       = $clog2(DEPTH);
    localparam logic [ADDR_W:0] c_DEPTH_X  = (ADDR_W+1)'(DEPTH);
    localparam logic [c_CNT_W-1:0] c_WAIT  = c_CNT_W'(WAIT_CYCLES);
    localparam logic [c_CNT_W-1:0] c_ONE   = c_CNT_W'(1);

    dm_state_e          r_state;
    dm_state_e          w_state_nxt;
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_we;
    logic [ADDR_W-1:0]  r_addr;
    logic [DATA_W-1:0]  r_wdata;
    logic               r_err;
    logic               r_rd_valid;

    logic               w_capture;
    logic               w_commit;
    logic               w_c_we;
    logic [ADDR_W-1:0]  w_c_addr;
    logic [DATA_W-1:0]  w_c_wdata;
    logic               w_in_range;
    logic               w_ram_en;
    logic [DATA_W-1:0]  w_ram_q;

    // State register; reset abandons any access in flight
    always_ff @(posedge clk) begin
        if (!rst_f) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state; w_commit marks the edge that enters RESP
    always_comb begin
        w_state_nxt = r_state;
        w_capture   = 1'b0;
        w_commit    = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (mem_req) begin
                    w_capture = 1'b1;
                    if (WAIT_CYCLES == 0) begin
                        w_state_nxt = ST_RESP;
                        w_commit    = 1'b1;
                    end else begin
                        w_state_nxt = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (r_cnt == c_ONE) begin
                    w_state_nxt = ST_RESP;
                    w_commit    = 1'b1;
                end
            end
            ST_RESP: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // With zero wait states the commit coincides with capture, so the
    // live request fields are used instead of the not-yet-loaded registers
    assign w_c_we     = (r_state == ST_IDLE) ? mem_we    : r_we;
    assign w_c_addr   = (r_state == ST_IDLE) ? mem_addr  : r_addr;
    assign w_c_wdata  = (r_state == ST_IDLE) ? mem_wdata : r_wdata;
    assign w_in_range = ({1'b0, w_c_addr} < c_DEPTH_X);
    assign w_ram_en   = rst_f && w_commit && w_in_range;

    // Request capture, wait counter and response flags
    always_ff @(posedge clk) begin
        if (!rst_f) begin
            r_cnt      <= '0;
            r_we       <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_err      <= 1'b0;
            r_rd_valid <= 1'b0;
        end else begin
            if (w_capture) begin
                r_we    <= mem_we;
                r_addr  <= mem_addr;
                r_wdata <= mem_wdata;
                r_cnt   <= c_WAIT;
            end else if (r_state == ST_WAIT) begin
                r_cnt <= r_cnt - c_ONE;
            end
            if (w_commit) begin
                r_err <= !w_in_range;
                if (!w_in_range) begin
                    r_rd_valid <= 1'b0;
                end else if (!w_c_we) begin
                    r_rd_valid <= 1'b1;
                end
            end
        end
    end

    sisc_dm_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AW     (c_AW)
    ) u_array (
        .clk     (clk),
        .i_en    (w_ram_en),
        .i_we    (w_c_we),
        .i_addr  (w_c_addr[c_AW-1:0]),
        .i_wdata (w_c_wdata),
        .o_rdata (w_ram_q)
    );

    // Stores leave the last load result visible; out-of-range forces zero
    assign mem_rdata = r_rd_valid ? w_ram_q : '0;
    assign mem_ack   = (r_state == ST_RESP);
    assign mem_err   = (r_state == ST_RESP) && r_err;
    assign mem_busy  = (r_state != ST_IDLE);

endmodule : sisc_dm_responder

`default_nettype wire
